// File: rtl/multicycle_control.sv
// Multi-cycle Moore sequencer for the Mini-MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/write-back.
module multicycle_control #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             PCSource,
  output logic [2:0]       ALUop,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] EXEC_R   = 4'd2;
  localparam logic [3:0] EXEC_I   = 4'd3;
  localparam logic [3:0] ALU_WB   = 4'd4;
  localparam logic [3:0] MEM_ADDR = 4'd5;
  localparam logic [3:0] MEM_RD   = 4'd6;
  localparam logic [3:0] MEM_WB   = 4'd7;
  localparam logic [3:0] MEM_WR   = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_rtype;
  logic             w_itype;
  logic             w_mem;
  logic             w_br;

  assign w_rtype = (op == 4'd0);
  assign w_itype = ((op >= 4'd1) && (op <= 4'd4)) || (op == 4'd7);
  assign w_mem   = (op == 4'd8) || (op == 4'd9);
  assign w_br    = (op == 4'd5) || (op == 4'd6);

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          w_rtype: w_next = EXEC_R;
          w_itype: w_next = EXEC_I;
          w_mem:   w_next = MEM_ADDR;
          w_br:    w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      EXEC_R:   w_next = ALU_WB;
      EXEC_I:   w_next = ALU_WB;
      MEM_ADDR: w_next = (op == 4'd8) ? MEM_RD : MEM_WR;
      MEM_RD:   w_next = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   w_next = mem_ready ? FETCH : MEM_WR;
      default:  w_next = FETCH;
    endcase
  end

  // An instruction retires on the edge leaving its final state
  assign w_retire = (r_state == ALU_WB) || (r_state == MEM_WB) ||
                    (r_state == BRANCH) ||
                    ((r_state == MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSource   = 1'b0;
    ALUop      = 3'b000;
    illegal_op = 1'b0;
    case (r_state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = 2'b10;
        illegal_op = !(w_rtype || w_itype || w_mem || w_br);
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUop   = 3'b110;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op)
          4'd2:    ALUop = 3'b001;
          4'd3:    ALUop = 3'b010;
          4'd4:    ALUop = 3'b011;
          4'd7:    ALUop = 3'b101;
          default: ALUop = 3'b000;
        endcase
      end
      ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = w_rtype;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUop    = 3'b100;
        PCSource = 1'b1;
        PCWrite  = (op == 4'd5) ? zero : ~zero;
      end
      default: ;
    endcase
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected traces
// built from the phase rules, checked every cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [3:0] op;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst;
  logic       MemtoReg, RegWrite, ALUSrcA, PCSource, illegal_op;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUop;
  logic [3:0] state;
  logic [7:0] retired;

  multicycle_control #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUop(ALUop), .state(state), .illegal_op(illegal_op),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // control word bit positions
  localparam int PCW = 15, IORD = 14, MR = 13, MW = 12, IRW = 11;
  localparam int RDST = 10, M2R = 9, RW = 8, SA = 7, SB1 = 6, SB0 = 5;
  localparam int PCS = 4, ILL = 0;

  typedef struct {
    logic        rst, rdy, zro;
    logic [3:0]  op, st;
    logic [15:0] ctl;
    logic [7:0]  ret;
  } ent_t;

  ent_t       q[$];
  ent_t       cur;
  logic       chk = 1'b0;
  int         n_cmp = 0, n_bad = 0, cyc = 0;
  logic [3:0] b_op;
  logic       b_z;
  logic [7:0] m_ret = 8'd0;

  function automatic logic [15:0] bit1(int p);
    logic [15:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] aop(logic [2:0] a);
    return {12'd0, a, 1'b0};
  endfunction

  task automatic push(logic [3:0] st, logic [15:0] ctl, logic rdy,
                      logic rst);
    ent_t e;
    e.rst = rst; e.rdy = rdy; e.zro = b_z; e.op = b_op;
    e.st = st; e.ctl = ctl; e.ret = m_ret;
    q.push_back(e);
  endtask

  // Expected cycle trace for one instruction
  task automatic add_instr(logic [3:0] o, logic z, int wf, int wm,
                           logic nz);
    logic [15:0] f;
    logic [2:0]  ia;
    b_op = o; b_z = z;
    f = bit1(MR) | bit1(SB0);
    for (int i = 0; i < wf; i++) push(4'd0, f, 1'b0, 1'b0);
    push(4'd0, f | bit1(PCW) | bit1(IRW), 1'b1, 1'b0);
    push(4'd1, bit1(SB1) | ((o > 4'd9) ? bit1(ILL) : 16'd0), nz, 1'b0);
    if (o > 4'd9) return;
    case (o)
      4'd0: begin
        push(4'd2, bit1(SA) | aop(3'b110), nz, 1'b0);
        push(4'd4, bit1(RW) | bit1(RDST), nz, 1'b0);
      end
      4'd1, 4'd2, 4'd3, 4'd4, 4'd7: begin
        case (o)
          4'd1: ia = 3'b000;
          4'd2: ia = 3'b001;
          4'd3: ia = 3'b010;
          4'd4: ia = 3'b011;
          default: ia = 3'b101;
        endcase
        push(4'd3, bit1(SA) | bit1(SB1) | aop(ia), nz, 1'b0);
        push(4'd4, bit1(RW), nz, 1'b0);
      end
      4'd8: begin
        push(4'd5, bit1(SA) | bit1(SB1), nz, 1'b0);
        for (int i = 0; i < wm; i++)
          push(4'd6, bit1(MR) | bit1(IORD), 1'b0, 1'b0);
        push(4'd6, bit1(MR) | bit1(IORD), 1'b1, 1'b0);
        push(4'd7, bit1(RW) | bit1(M2R), nz, 1'b0);
      end
      4'd9: begin
        push(4'd5, bit1(SA) | bit1(SB1), nz, 1'b0);
        for (int i = 0; i < wm; i++)
          push(4'd8, bit1(MW) | bit1(IORD), 1'b0, 1'b0);
        push(4'd8, bit1(MW) | bit1(IORD), 1'b1, 1'b0);
      end
      default: begin
        push(4'd9, bit1(SA) | aop(3'b100) | bit1(PCS) |
             (((o == 4'd5) ? z : !z) ? bit1(PCW) : 16'd0), nz, 1'b0);
      end
    endcase
    m_ret = m_ret + 8'd1;
  endtask

  // sw abandoned by reset while waiting in MEM_WR
  task automatic add_sw_reset();
    b_op = 4'd9; b_z = 1'b0;
    push(4'd0, bit1(MR) | bit1(SB0) | bit1(PCW) | bit1(IRW), 1'b1, 1'b0);
    push(4'd1, bit1(SB1), 1'b0, 1'b0);
    push(4'd5, bit1(SA) | bit1(SB1), 1'b0, 1'b0);
    push(4'd8, bit1(MW) | bit1(IORD), 1'b0, 1'b1);
    m_ret = 8'd0;
  endtask

  task automatic run();
    while (q.size() > 0) begin
      cur = q.pop_front();
      reset = cur.rst; op = cur.op; zero = cur.zro;
      mem_ready = cur.rdy; chk = 1'b1;
      @(posedge clk); #1;
    end
    chk = 1'b0;
  endtask

  task automatic lit(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] dv;
    cyc++;
    dv = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
          RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop, illegal_op};
    if (chk) begin
      n_cmp++;
      if (state !== cur.st || dv !== cur.ctl || retired !== cur.ret) begin
        n_bad++;
        $display("FAIL cycle %0d op=%0d: state got %0d exp %0d, ctl got %b exp %b, retired got %0d exp %0d",
                 cyc, cur.op, state, cur.st, dv, cur.ctl, retired, cur.ret);
      end
    end
  end

  initial begin
    reset = 1'b1; op = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset_state", state, 0);
    lit("reset_retired", retired, 0);
    lit("reset_memwrite", MemWrite, 0);

    add_instr(4'd0, 1'b0, 0, 0, 1'b1); run();
    lit("retired_after_add", retired, 1);
    add_instr(4'd8, 1'b0, 0, 2, 1'b0); run();
    lit("retired_after_lw", retired, 2);
    add_instr(4'd5, 1'b1, 0, 0, 1'b1);
    add_instr(4'd6, 1'b1, 0, 0, 1'b0); run();
    lit("retired_after_br", retired, 4);
    add_instr(4'd1, 1'b0, 1, 0, 1'b0);
    add_instr(4'd2, 1'b0, 0, 0, 1'b1);
    add_instr(4'd3, 1'b1, 0, 0, 1'b0);
    add_instr(4'd4, 1'b0, 2, 0, 1'b1);
    add_instr(4'd7, 1'b0, 0, 0, 1'b0); run();
    lit("retired_after_itype", retired, 9);
    add_instr(4'd12, 1'b0, 0, 0, 1'b1); run();
    lit("retired_after_illegal", retired, 9);
    add_instr(4'd9, 1'b0, 1, 1, 1'b1); run();
    lit("retired_after_sw", retired, 10);
    add_sw_reset(); run();
    lit("rst_mid_state", state, 0);
    lit("rst_mid_memwrite", MemWrite, 0);
    lit("rst_mid_retired", retired, 0);
    add_instr(4'd15, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 255; i++)
      add_instr(4'd5, i[0], 0, 0, i[1]);
    run();
    lit("retired_255", retired, 255);
    add_instr(4'd6, 1'b0, 0, 0, 1'b1); run();
    lit("retired_wrap", retired, 0);
    add_instr(4'd6, 1'b0, 0, 0, 1'b0); run();
    lit("retired_post_wrap", retired, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the Mini-MIPS datapath. A Moore FSM steps each instruction through fetch, decode, execute, memory and write-back. It drives the shared-ALU, register-file, PC and memory enables cycle by cycle, and stalls on a memory-ready handshake. It uses the same 4-bit opcode map and ALUop encoding as the single-cycle decoder, and adds a retired-instruction counter and an illegal-opcode flag.

## Interface
Parameters:
- CNT_W, 8, width of retired-instruction counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- op  in  4  opcode from instruction register; stable from DECODE until next FETCH
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  PC load enable
- IorD  out  1  0 = memory address from PC, 1 = from ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- RegDst  out  1  1 = rd, 0 = rt
- MemtoReg  out  1  1 = MDR to register file, 0 = ALUOut
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = reg B, 01 = constant 1, 10 = sign-extended immediate
- PCSource  out  1  0 = ALU result, 1 = ALUOut (branch target)
- ALUop  out  3  000 add, 001 and, 010 or, 011 nor, 100 subtract, 101 slt, 110 funct-driven
- state  out  4  current FSM state (debug)
- illegal_op  out  1  one-cycle pulse on undefined opcode
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

## Operation
- Opcode map: 0 R-type, 1 addi, 2 andi, 3 ori, 4 nori, 5 beq, 6 bne, 7 slti, 8 lw, 9 sw. Opcodes 10–15 are illegal.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9.
- Outputs are decoded from the state register (plus op in EXEC_I/ALU_WB/BRANCH). Any output not listed for a state is 0 there.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=000.
  - While mem_ready=0: hold in FETCH.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 (PC+1), then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUop=000 (branch target into ALUOut).
  - op 0 → EXEC_R; op 1–4 and 7 → EXEC_I; op 8–9 → MEM_ADDR; op 5–6 → BRANCH.
  - Illegal op → pulse illegal_op, go to FETCH; retired does not change.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUop=110 → ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUop per op (addi 000, andi 001, ori 010, nori 011, slti 101) → ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, RegDst=1 if op=0 else 0; retired+1 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=000 → MEM_RD if op=8, MEM_WR if op=9.
- MEM_RD: MemRead=1, IorD=1; hold until mem_ready, then → MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; retired+1 → FETCH.
- MEM_WR: MemWrite=1, IorD=1; hold until mem_ready, then retired+1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=100, PCSource=1.
  - PCWrite = zero for beq, ~zero for bne.
  - retired+1 → FETCH.

## Timing
- Reset (synchronous, any state): next edge gives state=FETCH, retired=0, illegal_op=0. All enables follow FETCH decode; MemWrite=0 and RegWrite=0 on the first cycle after reset.
- Reset mid-access abandons the access. There is no pending write-back and no counter increment.
- Latency with mem_ready high on the first request cycle: branch 3 cycles, R/I-type 4, sw 4, lw 5. Each extra wait cycle in FETCH/MEM_RD/MEM_WR adds 1.
- mem_ready is ignored in all states except FETCH, MEM_RD and MEM_WR.
- MemRead/MemWrite are held constant for the whole wait period. They drop the cycle after mem_ready.
- retired updates on the edge leaving ALU_WB, MEM_WB, MEM_WR(ready) or BRANCH. It wraps from 2^CNT_W−1 to 0 with no flag.
- Illegal op costs 2 cycles (FETCH, DECODE). illegal_op is high only during DECODE.

## Test plan
- Reset in MEM_WR with mem_ready=0 → next cycle state=0, MemWrite=0, retired=0.
- add (op=0), mem_ready=1 → states 0,1,2,4; ALUop=110 in EXEC_R; RegWrite=1, RegDst=1 in ALU_WB; retired 0→1.
- lw (op=8) with 2 wait cycles in MEM_RD → states 0,1,5,6,6,6,7; MemRead/IorD held high through all MEM_RD cycles; MemtoReg=1 in MEM_WB; total 7 cycles.
- beq (op=5) with zero=1 → PCWrite=1, PCSource=1 in BRANCH. bne (op=6) with zero=1 → PCWrite=0. Both increment retired.
- Each of ops 1,2,3,4,7 → ALUop in EXEC_I = 000, 001, 010, 011, 101 respectively; ALUSrcB=10.
- op=12 → illegal_op pulses in DECODE, return to FETCH, retired unchanged. With CNT_W=8, 256 retired instructions → retired wraps to 0.
